// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-arbiter FSM encoding and shifter datapath constants.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sarb_state_t;

  localparam int SHIFT_DATA_W   = 16;
  localparam int SHIFT_STEP_MAX = 15;

endpackage

// File: rtl/shifter_right.sv
// Single-pass 16-bit logical right shifter, 0..15 bits, built as a 4-stage log shifter.
module shifter_right
  import alu_pkg::*;
(
  input  logic [SHIFT_DATA_W-1:0] sftSrc,
  input  logic [3:0]              shamt,
  output logic [SHIFT_DATA_W-1:0] result
);

  logic [SHIFT_DATA_W-1:0] stage1;
  logic [SHIFT_DATA_W-1:0] stage2;
  logic [SHIFT_DATA_W-1:0] stage4;

  // Each stage conditionally shifts by one power of two; zeros fill from the top.
  always_comb begin
    stage1 = shamt[0] ? (sftSrc >> 1) : sftSrc;
    stage2 = shamt[1] ? (stage1 >> 2) : stage1;
    stage4 = shamt[2] ? (stage2 >> 4) : stage2;
    result = shamt[3] ? (stage4 >> 8) : stage4;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 0..15 bit right shifter between two requesters.
// Amounts up to 31 are applied as repeated passes; the result is held until the
// consumer takes it, tagged with the owning requester.
module shift_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W   = SHIFT_DATA_W,
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = SHIFT_STEP_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_src_i,
  input  logic [AMT_W-1:0]  req0_amt_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_src_i,
  input  logic [AMT_W-1:0]  req1_amt_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_id_o
);

  sarb_state_t       state;
  sarb_state_t       state_nxt;
  logic              prio;
  logic [DATA_W-1:0] acc;
  logic [AMT_W-1:0]  rem;
  logic              id;

  logic              grant0;
  logic              grant1;
  logic [AMT_W-1:0]  step;
  logic [AMT_W-1:0]  rem_after;
  logic [DATA_W-1:0] sft_result;
  logic              rsp_hs;

  // Round-robin grant: a sole requester wins, a tie goes to the pointer's choice.
  always_comb begin
    grant0 = req0_valid_i && (!req1_valid_i || !prio);
    grant1 = req1_valid_i && (!req0_valid_i ||  prio);
  end

  // Per-pass step is capped at what the shifter can do in one cycle.
  always_comb begin
    step      = (rem > AMT_W'(STEP_MAX)) ? AMT_W'(STEP_MAX) : rem;
    rem_after = rem - step;
  end

  shifter_right u_shifter (
    .sftSrc (acc),
    .shamt  (step[3:0]),
    .result (sft_result)
  );

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_nxt    = state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp_hs       = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        if (grant0 || grant1) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (rem_after == '0) state_nxt = DONE;
      end
      DONE: begin
        rsp_hs = rsp_ready_i;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand latch, pass iteration and round-robin pointer update.
  always_ff @(posedge clk_i) begin
    // NOTE: all datapath registers are reset so a reset mid-operation leaves no stale result visible on the outputs.
    if (rst_i) begin
      prio <= 1'b0;
      acc  <= '0;
      rem  <= '0;
      id   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready_o) begin
            acc <= req0_src_i;
            rem <= req0_amt_i;
            id  <= 1'b0;
          end else if (req1_ready_o) begin
            acc <= req1_src_i;
            rem <= req1_amt_i;
            id  <= 1'b1;
          end
        end
        SHIFT: begin
          acc <= sft_result;
          rem <= rem_after;
        end
        DONE: begin
          if (rsp_hs) prio <= ~id;
        end
        default: ;
      endcase
    end
  end

  // Response comes straight from the holding registers so it is stable under backpressure.
  always_comb begin
    rsp_valid_o = (state == DONE);
    rsp_data_o  = acc;
    rsp_id_o    = id;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: table of single transactions plus
// contention, backpressure and reset-mid-shift sequences.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_src;
  logic [4:0]  req0_amt;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_src;
  logic [4:0]  req1_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic [15:0] src;
    logic [4:0]  amt;
    logic [15:0] exp_data;
    int          passes;
  } vec_t;

  vec_t vecs[8];

  shift_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_src_i   (req0_src),
    .req0_amt_i   (req0_amt),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_src_i   (req1_src),
    .req1_amt_i   (req1_amt),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns the index of the first falling edge with rsp_valid high (0 on timeout).
  task automatic wait_rsp(input int maxc, output int k);
    bit seen;
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= maxc && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        k = i;
      end
    end
  endtask

  // One transaction from a single requester with rsp_ready high; valid is held
  // until the response handshake so the ready pulse width is observable.
  task automatic run_vec(input vec_t v);
    bit got;
    int k;
    int extra_ready;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_src = v.src; req0_amt = v.amt;
    end else begin
      req1_valid = 1'b1; req1_src = v.src; req1_amt = v.amt;
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = (v.id == 1'b0) ? req0_ready : req1_ready;
    end
    check("vec_accept", 32'(got), 32'd1);
    check("vec_other_ready", 32'((v.id == 1'b0) ? req1_ready : req0_ready), 32'd0);
    if (got) begin
      @(posedge clk);
      k = 0;
      extra_ready = 0;
      for (int i = 1; i <= 8 && k == 0; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) extra_ready++;
        if (rsp_valid) k = i;
      end
      check("vec_latency", 32'(k), 32'(v.passes + 1));
      check("vec_ready_pulse", 32'(extra_ready), 32'd0);
      check("vec_data", 32'(rsp_data), 32'(v.exp_data));
      check("vec_id", 32'(rsp_id), 32'(v.id));
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int k;
    int n;
    int both;
    int last_k;
    int drift;
    logic [15:0] held_data;
    logic        held_id;

    rst = 1'b1;
    req0_valid = 1'b0; req0_src = '0; req0_amt = '0;
    req1_valid = 1'b0; req1_src = '0; req1_amt = '0;
    rsp_ready = 1'b1;

    vecs[0] = '{1'b0, 16'hF0F0, 5'd4,  16'h0F0F, 1};
    vecs[1] = '{1'b0, 16'h8000, 5'd17, 16'h0000, 2};
    vecs[2] = '{1'b0, 16'h8000, 5'd31, 16'h0000, 3};
    vecs[3] = '{1'b0, 16'h8000, 5'd0,  16'h8000, 1};
    vecs[4] = '{1'b1, 16'hFFFF, 5'd15, 16'h0001, 1};
    vecs[5] = '{1'b1, 16'hFFFF, 5'd16, 16'h0000, 2};
    vecs[6] = '{1'b0, 16'hABCD, 5'd30, 16'h0000, 2};
    vecs[7] = '{1'b1, 16'h8001, 5'd1,  16'h4000, 1};

    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention: both continuously valid, grants alternate from req0.
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_src = 16'h1234; req0_amt = 5'd1;
    req1_valid = 1'b1; req1_src = 16'hFFFF; req1_amt = 5'd8;
    rsp_ready = 1'b1;
    n = 0; both = 0; last_k = 0; drift = 0;
    for (int i = 1; i <= 80 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both++;
      if (rsp_valid) begin
        check("cont_id", 32'(rsp_id), 32'(n % 2));
        check("cont_data", 32'(rsp_data), (n % 2 == 0) ? 32'h091A : 32'h00FF);
        if (n > 0 && (i - last_k) != 3) drift++;
        last_k = i;
        n++;
      end
    end
    check("cont_count", 32'(n), 32'd4);
    check("cont_both_ready", 32'(both), 32'd0);
    check("cont_period", 32'(drift), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: req0 wins (pointer back at 0), result held while req1 waits.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_src = 16'hA5A5; req0_amt = 5'd2;
    req1_valid = 1'b1; req1_src = 16'h00F0; req1_amt = 5'd4;
    @(negedge clk);
    check("bp_grant0", 32'(req0_ready), 32'd1);
    check("bp_loser", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(10, k);
    check("bp_rsp_seen", 32'(k != 0), 32'd1);
    check("bp_data", 32'(rsp_data), 32'h2969);
    check("bp_id", 32'(rsp_id), 32'd0);
    held_data = rsp_data;
    held_id = rsp_id;
    drift = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== held_data || rsp_id !== held_id || req1_ready) drift++;
    end
    check("bp_hold", 32'(drift), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready1_in_done", 32'(req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp_released", 32'(rsp_valid), 32'd0);
    check("bp_ready1_after", 32'(req1_ready), 32'd1);
    @(posedge clk);
    wait_rsp(10, k);
    check("bp_lat1", 32'(k), 32'd2);
    check("bp_data1", 32'(rsp_data), 32'h000F);
    check("bp_id1", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;

    // Reset mid-shift: set pointer to 1 first, then abort a 3-pass request.
    run_vec('{1'b0, 16'h0001, 5'd0, 16'h0001, 1});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_src = 16'hFFFF; req0_amt = 5'd31;
    @(negedge clk);
    check("rm_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rm_valid", 32'(rsp_valid), 32'd0);
    check("rm_data", 32'(rsp_data), 32'd0);
    check("rm_id", 32'(rsp_id), 32'd0);
    check("rm_ready0", 32'(req0_ready), 32'd0);
    check("rm_ready1", 32'(req1_ready), 32'd0);
    wait_rsp(6, k);
    check("rm_no_rsp", 32'(k), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_src = 16'h0F0F; req0_amt = 5'd4;
    req1_valid = 1'b1; req1_src = 16'h0F00; req1_amt = 5'd8;
    #2;
    check("rm_prio_r0", 32'(req0_ready), 32'd1);
    check("rm_prio_r1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    #1;
    check("rm_sole_r1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(10, k);
    check("rm_lat1", 32'(k), 32'd2);
    check("rm_data1", 32'(rsp_data), 32'h000F);
    check("rm_id1", 32'(rsp_id), 32'd1);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
